// File: rtl/pipe_reg_mw.sv
// MEM/WB-class pipeline register: DEPTH stages carrying an instruction bundle,
// with stall/flush control, in-flight destination lookup and perf counters.
module pipe_reg_mw #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                RA_W        = 5,
  parameter int                TYPE_W      = 4,
  parameter int                DEPTH       = 1,
  parameter logic [ADDR_W-1:0] PC_RESET    = 32'h0000_3000,
  parameter logic [TYPE_W-1:0] TYPE_BUBBLE = 4'd0,
  parameter int                CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] ir_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] wb_in,
  input  logic [RA_W-1:0]   rw_in,
  input  logic [TYPE_W-1:0] type_in,
  input  logic              regwr_in,
  output logic              valid_out,
  output logic [ADDR_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] wb_out,
  output logic [RA_W-1:0]   rw_out,
  output logic [TYPE_W-1:0] type_out,
  output logic              regwr_out,
  input  logic [RA_W-1:0]   query_ra,
  output logic              query_hit,
  output logic [DATA_W-1:0] query_data,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int LAST = DEPTH - 1;

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $fatal(1, "pipe_reg_mw: DEPTH must be in 1..4");
    end
  endgenerate

  // Index 0 is the youngest stage, LAST drives the outputs.
  logic              valid_q [DEPTH];
  logic [ADDR_W-1:0] ir_q    [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [DATA_W-1:0] wb_q    [DEPTH];
  logic [RA_W-1:0]   rw_q    [DEPTH];
  logic [TYPE_W-1:0] type_q  [DEPTH];
  logic              regwr_q [DEPTH];

  logic [CNT_W-1:0]  retired_q;
  logic [CNT_W-1:0]  stall_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ir_q[k]    <= '0;
        pc_q[k]    <= PC_RESET;
        wb_q[k]    <= '0;
        rw_q[k]    <= '0;
        type_q[k]  <= TYPE_BUBBLE;
        regwr_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      valid_q[0] <= valid_in;
      ir_q[0]    <= ir_in;
      pc_q[0]    <= pc_in;
      wb_q[0]    <= wb_in;
      rw_q[0]    <= rw_in;
      type_q[0]  <= type_in;
      regwr_q[0] <= regwr_in & valid_in;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        ir_q[k]    <= ir_q[k-1];
        pc_q[k]    <= pc_q[k-1];
        wb_q[k]    <= wb_q[k-1];
        rw_q[k]    <= rw_q[k-1];
        type_q[k]  <= type_q[k-1];
        regwr_q[k] <= regwr_q[k-1];
      end
    end

    // A valid bundle discarded by flush never counts as retired.
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else if (!flush) begin
      if (stall)
        stall_q <= stall_q + CNT_W'(1);
      else if (valid_q[LAST])
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign valid_out   = valid_q[LAST];
  assign ir_out      = ir_q[LAST];
  assign pc_out      = pc_q[LAST];
  assign wb_out      = wb_q[LAST];
  assign rw_out      = rw_q[LAST];
  assign type_out    = type_q[LAST];
  assign regwr_out   = regwr_q[LAST] & valid_q[LAST];
  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && regwr_q[k] && (rw_q[k] == query_ra) && (query_ra != '0)) begin
        query_hit  = 1'b1;
        query_data = wb_q[k];
      end
    end
  end

endmodule
